// File: rtl/spi_cfg_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_cfg_tx
// Purpose  : Serialises a 24-bit configuration frame {1'b0, gain, phase_inc}
//            onto a write-only SPI link, MSB first. CS is active low and SCK
//            idles low. Data changes on the SCK falling edge, so the far end
//            samples on the rising edge.
// Ports    : CLK        system clock, rising edge
//            RSTb       asynchronous active-low reset
//            start      one-cycle frame request
//            phase_inc  20-bit NCO phase increment to send
//            gain       3-bit gain code to send
//            CS/SCK/MOSI  SPI outputs, all driven straight from flops
//            busy       high from frame acceptance until done
//            done       one-cycle pulse at the end of each frame
// Options  : define SPI_CFG_TX_QUEUE_EN to add a one-entry pending buffer that
//            accepts a start while busy and launches it back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cfg_tx #(
  parameter int HALF_PERIOD = 4
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        start,
  input  logic [19:0] phase_inc,
  input  logic [2:0]  gain,
  output logic        CS,
  output logic        SCK,
  output logic        MOSI,
  output logic        busy,
  output logic        done
);

  // Counters run down to zero, so the reload value is length-1.
  localparam logic [8:0] C_HP_LAST  = 9'(HALF_PERIOD - 1);
  localparam logic [8:0] C_GAP_LAST = 9'(2 * HALF_PERIOD - 1);
  localparam logic [4:0] C_LAST_BIT = 5'd23;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_SCK_HI = 3'd2,
    S_SCK_LO = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t      r_state;
  logic [8:0]  r_hcnt;    // half-period (and gap) counter
  logic [4:0]  r_bcnt;    // index of the bit currently on MOSI
  logic [22:0] r_shift;   // bits still to be sent after the one on MOSI

  logic [23:0] w_frame;
  logic        w_cnt_end;
  logic        w_next_vld;   // a further frame is ready at the end of GAP
  logic [22:0] w_next_word;

  assign w_frame   = {1'b0, gain, phase_inc};
  assign w_cnt_end = (r_hcnt == 9'd0);

`ifdef SPI_CFG_TX_QUEUE_EN
  logic        r_pend_vld;
  logic [22:0] r_pend_word;

  // A start arriving on the last GAP cycle is newer than the buffer.
  assign w_next_vld  = start | r_pend_vld;
  assign w_next_word = start ? w_frame[22:0] : r_pend_word;
`else
  assign w_next_vld  = 1'b0;
  assign w_next_word = 23'd0;
`endif

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state     <= S_IDLE;
      r_hcnt      <= 9'd0;
      r_bcnt      <= 5'd0;
      r_shift     <= 23'd0;
      CS          <= 1'b1;
      SCK         <= 1'b0;
      MOSI        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SPI_CFG_TX_QUEUE_EN
      r_pend_vld  <= 1'b0;
      r_pend_word <= 23'd0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SPI_CFG_TX_QUEUE_EN
      // Latest request while busy overwrites any earlier pending one.
      if (busy && start) begin
        r_pend_vld  <= 1'b1;
        r_pend_word <= w_frame[22:0];
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SETUP;
            CS      <= 1'b0;
            busy    <= 1'b1;
            MOSI    <= w_frame[23];
            r_shift <= w_frame[22:0];
            r_bcnt  <= 5'd0;
            r_hcnt  <= C_HP_LAST;
          end
        end

        S_SETUP: begin
          if (w_cnt_end) begin
            r_state <= S_SCK_HI;
            SCK     <= 1'b1;
            r_hcnt  <= C_HP_LAST;
          end else begin
            r_hcnt <= r_hcnt - 9'd1;
          end
        end

        S_SCK_HI: begin
          if (w_cnt_end) begin
            // Data advances on the falling edge; after the last bit a zero
            // shifts out, which is what MOSI must show in GAP anyway.
            r_state <= S_SCK_LO;
            SCK     <= 1'b0;
            MOSI    <= r_shift[22];
            r_shift <= {r_shift[21:0], 1'b0};
            r_hcnt  <= C_HP_LAST;
          end else begin
            r_hcnt <= r_hcnt - 9'd1;
          end
        end

        S_SCK_LO: begin
          if (w_cnt_end) begin
            if (r_bcnt == C_LAST_BIT) begin
              r_state <= S_GAP;
              CS      <= 1'b1;
              MOSI    <= 1'b0;
              r_hcnt  <= C_GAP_LAST;
            end else begin
              r_state <= S_SCK_HI;
              SCK     <= 1'b1;
              r_bcnt  <= r_bcnt + 5'd1;
              r_hcnt  <= C_HP_LAST;
            end
          end else begin
            r_hcnt <= r_hcnt - 9'd1;
          end
        end

        S_GAP: begin
          if (w_cnt_end) begin
            done <= 1'b1;
            if (w_next_vld) begin
              // Chain straight into the next frame; busy stays high.
              r_state <= S_SETUP;
              CS      <= 1'b0;
              MOSI    <= 1'b0;
              r_shift <= w_next_word;
              r_bcnt  <= 5'd0;
              r_hcnt  <= C_HP_LAST;
`ifdef SPI_CFG_TX_QUEUE_EN
              r_pend_vld <= 1'b0;
`endif
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              r_hcnt  <= 9'd0;
            end
          end else begin
            r_hcnt <= r_hcnt - 9'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          CS      <= 1'b1;
          SCK     <= 1'b0;
          MOSI    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cfg_tx
// Purpose  : Self-checking bench for spi_cfg_tx. A frame-level model predicts
//            which start requests become frames and queues the expected
//            24-bit words; a monitor decodes the SPI pins and checks each
//            frame when done pulses. A second instance with HALF_PERIOD=7
//            is checked for exact SCK timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cfg_tx;

  localparam int H  = 4;
  localparam int H7 = 7;

  logic        CLK    = 1'b0;
  logic        clk_en = 1'b1;
  logic        RSTb   = 1'b0;
  logic        start  = 1'b0;
  logic [19:0] phase_inc = 20'd0;
  logic [2:0]  gain   = 3'd0;
  logic        CS, SCK, MOSI, busy, done;

  logic        start7 = 1'b0;
  logic [19:0] ph7    = 20'd0;
  logic [2:0]  g7     = 3'd0;
  logic        CS7, SCK7, MOSI7, busy7, done7;

  spi_cfg_tx #(.HALF_PERIOD(H)) u_dut (
    .CLK(CLK), .RSTb(RSTb), .start(start), .phase_inc(phase_inc), .gain(gain),
    .CS(CS), .SCK(SCK), .MOSI(MOSI), .busy(busy), .done(done)
  );

  spi_cfg_tx #(.HALF_PERIOD(H7)) u_dut7 (
    .CLK(CLK), .RSTb(RSTb), .start(start7), .phase_inc(ph7), .gain(g7),
    .CS(CS7), .SCK(SCK7), .MOSI(MOSI7), .busy(busy7), .done(done7)
  );

  always #5 if (clk_en) CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // A frame occupies 51*H clock edges from acceptance to done. Requests
  // while a frame is in flight are dropped, or held in one pending slot
  // when the queue option is built.
  int unsigned exp_q[$];
  bit          m_active = 0;
  bit          m_pend   = 0;
  int unsigned m_pend_word;
  int unsigned m_w;
  longint      m_t = 0;
  longint      m_done_edge = 0;

  task automatic new_frame(input int unsigned w);
    exp_q.push_back(w);
    m_active    = 1;
    m_done_edge = m_t + 51 * H;
  endtask

  initial forever begin
    @(posedge CLK);
    m_t++;
    if (!RSTb) begin
      m_active = 0;
      m_pend   = 0;
      exp_q.delete();
    end else begin
      m_w = int'(gain) * (1 << 20) + int'(phase_inc);
      if (m_active && m_t == m_done_edge) begin
`ifdef SPI_CFG_TX_QUEUE_EN
        if (start) begin
          new_frame(m_w);
          m_pend = 0;
        end else if (m_pend) begin
          new_frame(m_pend_word);
          m_pend = 0;
        end else begin
          m_active = 0;
        end
`else
        m_active = 0;
`endif
      end else if (m_active) begin
`ifdef SPI_CFG_TX_QUEUE_EN
        if (start) begin
          m_pend      = 1;
          m_pend_word = m_w;
        end
`endif
      end else if (start) begin
        new_frame(m_w);
      end
    end
  end

  // ---------------- pin monitor / scoreboard ----------------
  longint      mon_t = 0;
  longint      t_fall = 0;
  longint      cs_len = 0;
  int          nbits = 0;
  int unsigned cap = 0;
  int unsigned e;
  bit          prev_cs = 1;
  bit          prev_sck = 0;
  int          ndone = 0;

  initial forever begin
    @(negedge CLK);
    mon_t++;
    if (!RSTb) begin
      prev_cs  = 1;
      prev_sck = 0;
      nbits    = 0;
    end else begin
      // Evaluate done before a possible new CS fall on the same cycle.
      if (done) begin
        ndone++;
        chk("done_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("frame_word", cap & 32'hFF_FFFF, e);
        end
        chk("frame_bits", nbits, 24);
        chk("cs_low_cycles", cs_len, 49 * H);
        chk("done_delay", mon_t - t_fall, 51 * H);
      end
      if (prev_cs && !CS) begin
        t_fall = mon_t;
        nbits  = 0;
        cap    = 0;
      end
      if (!CS && SCK && !prev_sck) begin
        cap = (cap << 1) | 32'(MOSI);
        nbits++;
      end
      if (!prev_cs && CS) cs_len = mon_t - t_fall;
      if (!CS) begin
        chk("busy_in_frame", busy, 1);
      end else begin
        chk("idle_sck", SCK, 0);
        chk("idle_mosi", MOSI, 0);
      end
      prev_cs  = CS;
      prev_sck = SCK;
    end
  end

  // ---------------- far-end receiver (3-flop synchronised) ----------------
  logic [2:0]  sy_sck, sy_cs, sy_mosi;
  logic [23:0] rx_shift;
  logic [22:0] rx_word;
  bit          rx_prev_sck, rx_prev_cs;

  initial forever begin
    @(posedge CLK);
    if (!RSTb) begin
      sy_sck = 3'b000; sy_cs = 3'b111; sy_mosi = 3'b000;
      rx_shift = 24'd0; rx_word = 23'h507380;
      rx_prev_sck = 0; rx_prev_cs = 1;
    end else begin
      if (!sy_cs[2] && sy_sck[2] && !rx_prev_sck) rx_shift = {rx_shift[22:0], sy_mosi[2]};
      if (sy_cs[2] && !rx_prev_cs) rx_word = rx_shift[22:0];
      rx_prev_sck = sy_sck[2];
      rx_prev_cs  = sy_cs[2];
      sy_sck  = {sy_sck[1:0], SCK};
      sy_cs   = {sy_cs[1:0], CS};
      sy_mosi = {sy_mosi[1:0], MOSI};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [19:0] p, input logic [2:0] g);
    @(posedge CLK); #1;
    phase_inc = p; gain = g; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    // Scramble inputs so a late-sampling design would send garbage.
    phase_inc = 20'($urandom); gain = 3'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((m_active || m_pend || exp_q.size() != 0) && k < 3000) begin
      @(posedge CLK);
      k++;
    end
    repeat (4) @(posedge CLK);
    chk({name, "_drained"}, longint'(k < 3000), 1);
  endtask

  task automatic run_h7();
    longint t = 0, tf = 0, tr = 0, td = 0;
    int  hi_runs = 0, bad_runs = 0, ones = 0, run_len = 0;
    bit  run_val = 0, in_frame = 0, finished = 0;
    @(posedge CLK); #1 start7 = 1'b1;
    @(posedge CLK); #1 start7 = 1'b0;
    for (int i = 0; i < 500 && !finished; i++) begin
      @(negedge CLK);
      t++;
      if (!CS7) begin
        if (!in_frame) begin
          in_frame = 1; tf = t; run_val = SCK7; run_len = 1;
        end else if (SCK7 == run_val) begin
          run_len++;
        end else begin
          if (run_len != H7) bad_runs++;
          if (run_val) hi_runs++;
          run_val = SCK7; run_len = 1;
        end
        ones += int'(MOSI7);
      end else if (in_frame && tr == 0) begin
        tr = t;
        if (run_len != H7) bad_runs++;
        if (run_val) hi_runs++;
      end
      if (done7) begin
        td = t;
        finished = 1;
      end
    end
    chk("h7_finished", longint'(finished), 1);
    chk("h7_cs_low", tr - tf, 49 * H7);
    chk("h7_sck_highs", hi_runs, 24);
    chk("h7_bad_runs", bad_runs, 0);
    chk("h7_mosi_ones", ones, 0);
    chk("h7_done_delay", td - tf, 51 * H7);
  endtask

  // ---------------- main sequence ----------------
  int d0;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cs", CS, 1);
    chk("rst_sck", SCK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge CLK) RSTb = 1'b1;

    // Known frame, plus loopback into the receiver.
    d0 = ndone;
    send(20'h12345, 3'd5);
    wait_idle("frame_12345");
    chk("rx_phase", rx_word[19:0], 20'h12345);
    chk("rx_gain", rx_word[22:20], 5);
    chk("frame_12345_dones", ndone - d0, 1);

    // Second start 20 cycles into a frame.
    d0 = ndone;
    send(20'h0ABCD, 3'd2);
    repeat (18) @(posedge CLK);
    send(20'hFFFFF, 3'd2);
    wait_idle("busy_start");
`ifdef SPI_CFG_TX_QUEUE_EN
    chk("busy_start_dones", ndone - d0, 2);
    chk("rx_after_queue", rx_word, 23'h2FFFFF);

    // Two requests during one frame: the later one wins.
    d0 = ndone;
    send(20'h00000, 3'd0);
    repeat (10) @(posedge CLK);
    send(20'h00001, 3'd1);
    repeat (10) @(posedge CLK);
    send(20'h00002, 3'd1);
    wait_idle("queue_pair");
    chk("queue_pair_dones", ndone - d0, 2);
    chk("rx_queue_pair", rx_word, 23'h100002);
`else
    chk("busy_start_dones", ndone - d0, 1);
    chk("rx_after_ignore", rx_word, 23'h20ABCD);
`endif

    // Random requests at random spacing, some landing while busy.
    for (int i = 0; i < 16; i++) begin
      send(20'($urandom), 3'($urandom));
      repeat ($urandom_range(1, 230)) @(posedge CLK);
    end
    wait_idle("random");

    // Asynchronous reset mid-frame with the clock stopped.
    d0 = ndone;
    send(20'h55555, 3'd7);
    repeat (60) @(posedge CLK);
    @(negedge CLK);
    clk_en = 1'b0;
    #3 RSTb = 1'b0;
    #1;
    chk("abort_cs", CS, 1);
    chk("abort_sck", SCK, 0);
    chk("abort_mosi", MOSI, 0);
    chk("abort_busy", busy, 0);
    #20 clk_en = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RSTb = 1'b1;
    repeat (300) @(posedge CLK);
    chk("abort_no_done", ndone - d0, 0);
    chk("abort_idle_cs", CS, 1);

    run_h7();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_cfg_tx.md
SPI_CFG_TX -- requirements
Module: spi_cfg_tx

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4: SCK high time and low time, in CLK cycles; legal range 4..255.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RSTb  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to send one configuration frame.
REQ-005 SHALL have port phase_inc  input  20  NCO phase increment to send.
REQ-006 SHALL have port gain  input  3  gain code to send.
REQ-007 SHALL have port CS  output  1  SPI chip select; active low.
REQ-008 SHALL have port SCK  output  1  SPI clock; idles low.
REQ-009 SHALL have port MOSI  output  1  SPI serial data.
REQ-010 SHALL have port busy  output  1  high from frame acceptance until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of each frame.

Function
REQ-012 SHALL send a 24-bit frame {1'b0, gain, phase_inc}, MSB (bit 23) first.
REQ-013 SHALL capture the frame word into an internal shift register on the edge where start is accepted; later input changes SHALL NOT affect the frame.
REQ-014 SHALL implement states IDLE, SETUP, SCK_HI, SCK_LO, GAP.
REQ-015 IDLE: CS=1, SCK=0, MOSI=0, busy=0; start=1 -> SETUP; CS=0, busy=1, MOSI=bit 23 from next cycle.
REQ-016 SETUP: hold CS=0, SCK=0 for HALF_PERIOD cycles -> SCK_HI.
REQ-017 SCK_HI: SCK=1 for HALF_PERIOD cycles, MOSI stable -> SCK_LO.
REQ-018 SCK_LO: SCK=0 for HALF_PERIOD cycles; MOSI SHALL advance to the next bit on the SCK high->low transition; after the 24th bit's low phase -> GAP; otherwise -> SCK_HI.
REQ-019 Exactly 24 SCK rising edges per frame; CS low duration SHALL be 49*HALF_PERIOD cycles.
REQ-020 GAP: CS=1, SCK=0, MOSI=0 for 2*HALF_PERIOD cycles; then done=1 for one cycle, busy=0 on that same edge, -> IDLE.
REQ-021 done SHALL rise 51*HALF_PERIOD cycles after CS falls.
REQ-022 A bit counter of 5 bits SHALL count 0..23 with no wrap; a half-period counter SHALL reload at every state change.
REQ-023 start while busy=1 SHALL be ignored (see REQ-027 for the alternative).
REQ-024 CS, SCK, MOSI SHALL be driven directly from flops (glitch-free).

Reset
REQ-025 RSTb=0 SHALL immediately force state=IDLE, CS=1, SCK=0, MOSI=0, busy=0, done=0, counters and shift register=0, independent of CLK.
REQ-026 Reset mid-frame SHALL abort without a done pulse; the partial frame is delivered to the far end as a short frame (CS rises).

Configuration
REQ-027 With macro SPI_CFG_TX_QUEUE_EN defined, SHALL include a one-entry pending buffer: start while busy captures {gain, phase_inc} (latest overwrites earlier); at the end of GAP, done pulses, busy stays 1, and the pending frame starts in SETUP on the next cycle; without the macro, REQ-023 applies and no buffer exists.

Verification
REQ-028 Reset: assert RSTb=0 mid-frame with CLK stopped -> CS=1, SCK=0, MOSI=0, busy=0 immediately; no done after release.
REQ-029 HALF_PERIOD=4, phase_inc=0x12345, gain=5, start pulse -> MOSI bits at 24 SCK rises = 0x512345 MSB first; CS low 196 cycles; done 204 cycles after CS fall.
REQ-030 Loopback into the configuration receiver (3-flop synchronised, reset default 0x507380): after done, receiver phase_inc=0x12345, gain=5.
REQ-031 Without macro: second start 20 cycles into frame with phase_inc=0xFFFFF -> ignored; exactly one frame, one done.
REQ-032 With SPI_CFG_TX_QUEUE_EN: two starts during frame (0x00001 then 0x00002, gain 1) -> two frames back-to-back, second carries 0x100002, two done pulses, busy continuous.
REQ-033 HALF_PERIOD=7, phase_inc=0, gain=0 -> SCK high/low exactly 7 cycles each, CS low 343 cycles, MOSI constant 0.
